load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator side of the data-memory port in the RV32I core. It takes load/store requests from the execute stage and drives the word-wide, word-indexed data memory (address, write data, write enable, combinational read data).
- Sub-word stores are word-only at the memory, so they are done as read-modify-write.
- Loads are extracted per RV32I: LB/LH sign-extend, LBU/LHU zero-extend.
- Misaligned, illegal or out-of-range requests are rejected without any memory access.

Parameters:
- DEPTH, 1024, number of 32-bit words in data memory; word index >= DEPTH is out of range.
- AW, 32, width of the byte address and of mem_A.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-low.
- req_valid  in  1  request present; held stable until accepted.
- req_ready  out  1  high only in IDLE; a request is accepted at a posedge with req_valid & req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- req_addr  in  AW  byte address.
- req_wdata  in  32  store data; the low byte or halfword is used for SB/SH.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load result; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid: misaligned, illegal funct3 or out of range.
- mem_A  out  AW  word index = latched addr >> 2; 0 when idle.
- mem_WD  out  32  write word; 0 when mem_WE is low.
- mem_WE  out  1  write enable; the memory writes on posedge.
- mem_RD  in  32  combinational read data for mem_A.

Behaviour:
- Reset: rst==0 at a posedge gives state IDLE and clears resp_valid, resp_rdata, resp_err and the latched request.
- mem_WE = rst & (state==STORE | state==RMW_WR). It is gated combinationally, so asserting reset in any cycle suppresses the write at that edge.
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, DONE.
- On acceptance (IDLE), addr, we, funct3 and wdata are latched, then:
  - Error request goes to DONE with err=1 and no memory access.
  - Load goes to LOAD.
  - SW goes to STORE.
  - SB/SH go to RMW_RD.
- LOAD: drives mem_A. At the next edge, the extracted and extended mem_RD is registered into resp_rdata, then DONE.
- STORE: mem_A and mem_WD = wdata, mem_WE=1. The write happens at the exiting edge, then DONE.
- RMW_RD: drives mem_A and registers mem_RD into a merge buffer, then RMW_WR.
- RMW_WR: mem_WD = buffer with lane(s) replaced; mem_WE=1, then DONE.
- DONE: resp_valid=1 for exactly one cycle, then IDLE. req_ready=0 in DONE, so there is no overlap between a response and a new acceptance.
- Latency from acceptance edge to resp_valid cycle:
  - Load: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Error: 1 cycle.
- Lanes:
  - Byte lane = addr[1:0]; lane 0 is bits 7:0 (little-endian).
  - Half lane = addr[1]; lane 0 is bits 15:0.
- Errors:
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]!=0.
  - Load funct3 in {011,110,111}.
  - Store funct3 > 010.
  - (addr>>2) >= DEPTH.
- Exactly one mem_WE cycle per successful store; zero for loads and errors.
- req_valid outside IDLE is ignored; the requester holds it.

Decomposition:
- Package lsu_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State encoding localparams.
  - Lane-select helper widths.
- One combinational sub-module, lsu_align:
  - Load extract/extend from word, lane and funct3.
  - Store merge of old word, new data, lane and size.
  - Shared by the LOAD and RMW_WR paths.

Test Plan:
- Preload word 7 = 0x1234_80F6:
  - LB 0x1C → 0xFFFF_FFF6.
  - LBU 0x1D → 0x0000_0080.
  - LH 0x1C → 0xFFFF_80F6.
  - LHU 0x1E → 0x0000_1234.
  - Each has resp_valid 2 cycles after acceptance, err=0, mem_WE never high.
- SB 0x1D, wdata 0xAABB_CC55 → word 7 = 0x1234_55F6, mem_WE high exactly 1 cycle, resp_valid 3 cycles after acceptance.
- SH 0x1E, wdata 0x0000_BEEF → word 7 = 0xBEEF_80F6; then SW 0x20, wdata 0xDEAD_BEEF, then LW 0x20 → 0xDEAD_BEEF.
- Error cases, each giving err=1, rdata=0, resp_valid 1 cycle after acceptance, memory unchanged:
  - LW 0x22.
  - SH 0x1F.
  - Load funct3 011.
  - LW 0x1000 with DEPTH=1024.
- rst=0 during the RMW_WR cycle of SH 0x1C → mem_WE low at that edge, word 7 unchanged, resp_valid 0, req_ready=1 the cycle after rst returns high.
- Back-to-back: req_valid held continuously for LW then SW → second accepted only in IDLE after the first DONE; req_ready low during LOAD/DONE.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and request-legality helper for the load/store unit.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int LANE_W = 2;
   localparam int BYTE_W = 8;
   localparam int HALF_W = 16;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_STORE  = 3'd2,
      S_RMW_RD = 3'd3,
      S_RMW_WR = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   // Alignment and funct3 legality; range checking is done by the caller.
   function automatic logic req_illegal(input logic i_we, input logic [2:0] i_f3,
                                        input logic [LANE_W-1:0] i_lo);
      logic w_bad;
      w_bad = 1'b1;
      if (i_we) begin
         case (i_f3)
            F3_B:    w_bad = 1'b0;
            F3_H:    w_bad = i_lo[0];
            F3_W:    w_bad = (i_lo != 2'b00);
            default: w_bad = 1'b1;
         endcase
      end else begin
         case (i_f3)
            F3_B, F3_BU: w_bad = 1'b0;
            F3_H, F3_HU: w_bad = i_lo[0];
            F3_W:        w_bad = (i_lo != 2'b00);
            default:     w_bad = 1'b1;
         endcase
      end
      return w_bad;
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake and word-wide data-memory port of the load/store unit.
interface load_store_unit_if #(parameter int AW = 32);
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [2:0]    req_funct3;
   logic [AW-1:0] req_addr;
   logic [31:0]   req_wdata;
   logic          resp_valid;
   logic [31:0]   resp_rdata;
   logic          resp_err;
   logic [AW-1:0] mem_A;
   logic [31:0]   mem_WD;
   logic          mem_WE;
   logic [31:0]   mem_RD;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_RD,
      input  req_ready, resp_valid, resp_rdata, resp_err, mem_A, mem_WD, mem_WE
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_RD,
      output req_ready, resp_valid, resp_rdata, resp_err, mem_A, mem_WD, mem_WE
   );
endinterface

// File: rtl/lsu_align.sv
// Lane extraction with RV32I sign/zero extension, and sub-word merge for read-modify-write.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [31:0]       i_word,
   input  logic [LANE_W-1:0] i_lane,
   input  logic [2:0]        i_funct3,
   input  logic [HALF_W-1:0] i_wdata,
   output logic [31:0]       o_load,
   output logic [31:0]       o_merge
);
   logic [BYTE_W-1:0] w_byte;
   logic [HALF_W-1:0] w_half;

   always_comb begin
      case (i_lane)
         2'd0:    w_byte = i_word[7:0];
         2'd1:    w_byte = i_word[15:8];
         2'd2:    w_byte = i_word[23:16];
         default: w_byte = i_word[31:24];
      endcase
      w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

      case (i_funct3)
         F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
         F3_BU:   o_load = {24'd0, w_byte};
         F3_H:    o_load = {{16{w_half[15]}}, w_half};
         F3_HU:   o_load = {16'd0, w_half};
         default: o_load = i_word;
      endcase

      o_merge = i_word;
      if (i_funct3 == F3_B)
         o_merge[{i_lane, 3'b000} +: BYTE_W] = i_wdata[7:0];
      else if (i_funct3 == F3_H)
         o_merge[{i_lane[1], 4'b0000} +: HALF_W] = i_wdata;
   end
endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: word loads/stores direct, sub-word stores via read-modify-write.
//  state    | meaning
//  S_IDLE   | ready; latch request on valid
//  S_LOAD   | drive mem_A, register extended read data
//  S_STORE  | full-word write
//  S_RMW_RD | read old word into merge buffer
//  S_RMW_WR | write merged word
//  S_DONE   | one-cycle response
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int AW    = 32
) (
   input logic              clk,
   input logic              rst,
   load_store_unit_if.slave lsu
);
   localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);

   state_t        r_state;
   logic [AW-1:0] r_addr;
   logic          r_we;
   logic [2:0]    r_f3;
   logic [31:0]   r_wdata;
   logic [31:0]   r_buf;
   logic [31:0]   r_rdata;
   logic          r_err;
   logic          r_valid;

   logic [AW-1:0] w_req_widx;
   logic          w_req_err;
   logic [31:0]   w_align_word;
   logic [31:0]   w_load;
   logic [31:0]   w_merge;
   logic          w_mem_phase;

   assign w_req_widx   = lsu.req_addr >> 2;
   assign w_req_err    = req_illegal(lsu.req_we, lsu.req_funct3, lsu.req_addr[1:0])
                         | (w_req_widx >= DEPTH_W);
   assign w_align_word = (r_state == S_RMW_WR) ? r_buf : lsu.mem_RD;

   lsu_align u_align (
      .i_word   (w_align_word),
      .i_lane   (r_addr[1:0]),
      .i_funct3 (r_f3),
      .i_wdata  (r_wdata[15:0]),
      .o_load   (w_load),
      .o_merge  (w_merge)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_we    <= 1'b0;
         r_f3    <= '0;
         r_wdata <= '0;
         r_buf   <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (lsu.req_valid) begin
                  r_addr  <= lsu.req_addr;
                  r_we    <= lsu.req_we;
                  r_f3    <= lsu.req_funct3;
                  r_wdata <= lsu.req_wdata;
                  r_rdata <= '0;
                  r_err   <= w_req_err;
                  if (w_req_err) begin
                     r_state <= S_DONE;
                     r_valid <= 1'b1;
                  end else if (!lsu.req_we)
                     r_state <= S_LOAD;
                  else if (lsu.req_funct3 == F3_W)
                     r_state <= S_STORE;
                  else
                     r_state <= S_RMW_RD;
               end
            end
            S_LOAD: begin
               r_rdata <= w_load;
               r_state <= S_DONE;
               r_valid <= 1'b1;
            end
            S_STORE, S_RMW_WR: begin
               r_state <= S_DONE;
               r_valid <= 1'b1;
            end
            S_RMW_RD: begin
               r_buf   <= lsu.mem_RD;
               r_state <= S_RMW_WR;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Write enable is gated by rst directly so a reset edge never commits a write.
   assign w_mem_phase    = (r_state == S_LOAD) || (r_state == S_STORE)
                           || (r_state == S_RMW_RD) || (r_state == S_RMW_WR);
   assign lsu.mem_A      = w_mem_phase ? (r_addr >> 2) : '0;
   assign lsu.mem_WE     = rst & ((r_state == S_STORE) || (r_state == S_RMW_WR));
   assign lsu.mem_WD     = !lsu.mem_WE ? 32'd0 : ((r_state == S_STORE) ? r_wdata : w_merge);
   assign lsu.req_ready  = (r_state == S_IDLE);
   assign lsu.resp_valid = r_valid;
   assign lsu.resp_rdata = r_rdata;
   assign lsu.resp_err   = r_err;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word-indexed memory model.
module tb_load_store_unit;
   import lsu_pkg::*;

   logic clk;
   logic rst;
   int   tests;
   int   fails;

   logic [31:0] mem [0:1023];
   logic        pre_en;
   logic [9:0]  pre_idx;
   logic [31:0] pre_val;

   load_store_unit_if #(.AW(32)) bus ();

   load_store_unit #(.DEPTH(1024), .AW(32)) dut (
      .clk (clk),
      .rst (rst),
      .lsu (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bus.mem_RD = (bus.mem_A < 32'd1024) ? mem[bus.mem_A[9:0]] : 32'd0;

   always @(posedge clk) begin
      if (pre_en)
         mem[pre_idx] <= pre_val;
      else if (bus.mem_WE)
         mem[bus.mem_A[9:0]] <= bus.mem_WD;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [9:0] idx, input logic [31:0] val);
      pre_idx = idx;
      pre_val = val;
      pre_en  = 1'b1;
      @(posedge clk);
      #1 pre_en = 1'b0;
   endtask

   // Issue one request, then measure latency (edges from acceptance) and write-enable cycles.
   task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int exp_lat, input int exp_we,
                          input logic exp_err, input logic [31:0] exp_rdata);
      int   lat;
      int   wes;
      int   guard;
      logic got;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wd;
      bus.req_valid  = 1'b1;
      guard = 0;
      @(negedge clk);
      while (!bus.req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check({tag, " ready"}, 32'(bus.req_ready), 32'd1);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      lat = 1;
      wes = 0;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (bus.mem_WE) wes++;
         if (bus.resp_valid) got = 1'b1;
         else lat++;
      end
      check({tag, " resp_seen"}, 32'(got), 32'd1);
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " we_cycles"}, 32'(wes), 32'(exp_we));
      check({tag, " err"}, 32'(bus.resp_err), 32'(exp_err));
      check({tag, " rdata"}, bus.resp_rdata, exp_rdata);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tests          = 0;
      fails          = 0;
      rst            = 1'b0;
      pre_en         = 1'b0;
      pre_idx        = '0;
      pre_val        = '0;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_funct3 = '0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;

      poke(10'd7, 32'h1234_80F6);
      poke(10'd8, 32'h0000_0000);
      poke(10'd9, 32'h0000_0000);
      @(negedge clk);
      check("rst req_ready", 32'(bus.req_ready), 32'd1);
      check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst resp_err", 32'(bus.resp_err), 32'd0);
      check("rst resp_rdata", bus.resp_rdata, 32'd0);
      check("rst mem_A", bus.mem_A, 32'd0);
      check("rst mem_WE", 32'(bus.mem_WE), 32'd0);
      rst = 1'b1;

      run_req("LB 1C",  1'b0, F3_B,  32'h1C, 32'd0, 2, 0, 1'b0, 32'hFFFF_FFF6);
      run_req("LBU 1D", 1'b0, F3_BU, 32'h1D, 32'd0, 2, 0, 1'b0, 32'h0000_0080);
      run_req("LH 1C",  1'b0, F3_H,  32'h1C, 32'd0, 2, 0, 1'b0, 32'hFFFF_80F6);
      run_req("LHU 1E", 1'b0, F3_HU, 32'h1E, 32'd0, 2, 0, 1'b0, 32'h0000_1234);

      run_req("SB 1D", 1'b1, F3_B, 32'h1D, 32'hAABB_CC55, 3, 1, 1'b0, 32'd0);
      check("SB word7", mem[7], 32'h1234_55F6);

      poke(10'd7, 32'h1234_80F6);
      run_req("SH 1E", 1'b1, F3_H, 32'h1E, 32'h0000_BEEF, 3, 1, 1'b0, 32'd0);
      check("SH word7", mem[7], 32'hBEEF_80F6);

      run_req("SW 20", 1'b1, F3_W, 32'h20, 32'hDEAD_BEEF, 2, 1, 1'b0, 32'd0);
      check("SW word8", mem[8], 32'hDEAD_BEEF);
      run_req("LW 20", 1'b0, F3_W, 32'h20, 32'd0, 2, 0, 1'b0, 32'hDEAD_BEEF);

      run_req("err LW 22",    1'b0, F3_W,   32'h22,   32'd0,        1, 0, 1'b1, 32'd0);
      run_req("err SH 1F",    1'b1, F3_H,   32'h1F,   32'h0000_1111, 1, 0, 1'b1, 32'd0);
      run_req("err LD f3=3",  1'b0, 3'b011, 32'h1C,   32'd0,        1, 0, 1'b1, 32'd0);
      run_req("err LW 1000",  1'b0, F3_W,   32'h1000, 32'd0,        1, 0, 1'b1, 32'd0);
      run_req("err ST f3=3",  1'b1, 3'b011, 32'h20,   32'h5555_5555, 1, 0, 1'b1, 32'd0);
      check("err word7", mem[7], 32'hBEEF_80F6);
      check("err word8", mem[8], 32'hDEAD_BEEF);

      // Reset asserted during the RMW_WR cycle of SH 0x1C.
      @(negedge clk);
      bus.req_we     = 1'b1;
      bus.req_funct3 = F3_H;
      bus.req_addr   = 32'h1C;
      bus.req_wdata  = 32'h0000_1111;
      bus.req_valid  = 1'b1;
      check("rstwr ready", 32'(bus.req_ready), 32'd1);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rstwr mem_WE", 32'(bus.mem_WE), 32'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("rstwr ready after", 32'(bus.req_ready), 32'd1);
      check("rstwr resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rstwr word7", mem[7], 32'hBEEF_80F6);
      @(negedge clk);
      check("rstwr no late resp", 32'(bus.resp_valid), 32'd0);

      // Back-to-back with req_valid held: LW 0x20 then SW 0x24.
      bus.req_we     = 1'b0;
      bus.req_funct3 = F3_W;
      bus.req_addr   = 32'h20;
      bus.req_wdata  = 32'd0;
      bus.req_valid  = 1'b1;
      check("b2b ready idle", 32'(bus.req_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      check("b2b ready LOAD", 32'(bus.req_ready), 32'd0);
      check("b2b valid LOAD", 32'(bus.resp_valid), 32'd0);
      @(negedge clk);
      check("b2b ready DONE", 32'(bus.req_ready), 32'd0);
      check("b2b valid DONE", 32'(bus.resp_valid), 32'd1);
      check("b2b LW rdata", bus.resp_rdata, 32'hDEAD_BEEF);
      bus.req_we     = 1'b1;
      bus.req_addr   = 32'h24;
      bus.req_wdata  = 32'h0BAD_F00D;
      @(negedge clk);
      check("b2b ready idle2", 32'(bus.req_ready), 32'd1);
      check("b2b valid idle2", 32'(bus.resp_valid), 32'd0);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      check("b2b SW mem_WE", 32'(bus.mem_WE), 32'd1);
      check("b2b SW mem_A", bus.mem_A, 32'd9);
      check("b2b SW mem_WD", bus.mem_WD, 32'h0BAD_F00D);
      @(negedge clk);
      check("b2b SW resp_valid", 32'(bus.resp_valid), 32'd1);
      check("b2b SW err", 32'(bus.resp_err), 32'd0);
      check("b2b word9", mem[9], 32'h0BAD_F00D);
      check("b2b word8", mem[8], 32'hDEAD_BEEF);
      @(negedge clk);
      check("b2b idle mem_A", bus.mem_A, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
